redmule_z_store_buffer: RTL and testbench

// - Output-side counterpart of the X input buffer. It collects one result column per beat from the

---
 rtl/redmule_pkg.sv | 30 +++
 rtl/redmule_z_store_bank.sv | 44 ++++
 rtl/redmule_z_store_buffer.sv | 152 +++++++++++++++
 tb/tb_redmule_z_store_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE datapath slice.
// The element-format enum is kept local so this slice compiles without the FPU packages.
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH = 12;

    typedef enum logic [2:0] {
        FP32,
        FP64,
        FP16,
        FP8,
        FP16ALT
    } fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:          return 32;
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            FP8:           return 8;
            default:       return 16;
        endcase
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
    } z_store_flgs_t;

endpackage

// File: rtl/redmule_z_store_bank.sv
// One W x N x BITW register bank: whole-column writes, combinational whole-row reads.
// Storage is deliberately not reset.
module redmule_z_store_bank #(
    parameter int unsigned DW    = 288,
    parameter int unsigned BITW  = 16,
    parameter int unsigned Width = 12,
    localparam int unsigned N    = DW / BITW,
    localparam int unsigned CIW  = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned RIW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic                        clk_i,
    input  logic                        wr_en,
    input  logic [CIW-1:0]              wr_col,
    input  logic [Width-1:0][BITW-1:0]  wr_data,
    input  logic [RIW-1:0]              rd_row,
    output logic [DW-1:0]               rd_data
);

    logic [Width-1:0][N*BITW-1:0] row_words;

    genvar gi, gj;
    generate
        for (gi = 0; gi < Width; gi++) begin : g_row
            logic [BITW-1:0] row_mem [N];

            always_ff @(posedge clk_i) begin
                if (wr_en) begin
                    row_mem[wr_col] <= wr_data[gi];
                end
            end

            for (gj = 0; gj < N; gj++) begin : g_col
                assign row_words[gi][gj*BITW +: BITW] = row_mem[gj];
            end
        end

        if (N * BITW < DW) begin : g_pad
            assign rd_data[DW-1:N*BITW] = '0;
        end
    endgenerate

    assign rd_data[N*BITW-1:0] = row_words[rd_row];

endmodule

// File: rtl/redmule_z_store_buffer.sv
// Ping-pong Z buffer: collects result columns from the array into a row-major tile
// in one bank while the other bank drains to the store streamer one row per word.
module redmule_z_store_buffer
    import redmule_pkg::*;
#(
    parameter int unsigned DW       = 288,
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned Width    = ARRAY_WIDTH,
    localparam int unsigned BITW    = fp_width(FpFormat),
    localparam int unsigned N       = DW / BITW,
    localparam int unsigned CW      = $clog2(N) + 1,
    localparam int unsigned RW      = $clog2(Width) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic [CW-1:0]               cfg_cols_i,
    input  logic [RW-1:0]               cfg_rows_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [Width-1:0][BITW-1:0]  in_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DW-1:0]               out_data_o,
    output logic [DW/8-1:0]             out_strb_o,
    output z_store_flgs_t               flags_o
);

    localparam int unsigned CIW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RIW = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned BB  = BITW / 8;

    logic                  wr_bank_reg, wr_bank_next;
    logic                  rd_bank_reg, rd_bank_next;
    logic [1:0]            bank_full_reg, bank_full_next;
    logic [CW-1:0]         wr_col_reg, wr_col_next;
    logic [RW-1:0]         rd_row_reg, rd_row_next;
    logic [1:0][CW-1:0]    cols_lim_reg, cols_lim_next;
    logic [1:0][RW-1:0]    rows_lim_reg, rows_lim_next;

    logic [CW-1:0]         cfg_cols_map, col_limit, cols_rd;
    logic [RW-1:0]         cfg_rows_map;
    logic                  push, pop;
    logic [1:0][DW-1:0]    bank_word;
    logic [DW-1:0]         rd_word;

    assign cfg_cols_map = (cfg_cols_i == '0) ? CW'(N) : cfg_cols_i;
    assign cfg_rows_map = (cfg_rows_i == '0) ? RW'(Width) : cfg_rows_i;

    // The first column of a tile uses the live config; later columns the latched one.
    assign col_limit = (wr_col_reg == '0) ? cfg_cols_map : cols_lim_reg[wr_bank_reg];

    assign in_ready_o  = ~bank_full_reg[wr_bank_reg];
    assign out_valid_o = bank_full_reg[rd_bank_reg];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign flags_o.empty = ~|bank_full_reg;
    assign flags_o.full  = &bank_full_reg;

    always_comb begin
        wr_bank_next   = wr_bank_reg;
        rd_bank_next   = rd_bank_reg;
        bank_full_next = bank_full_reg;
        wr_col_next    = wr_col_reg;
        rd_row_next    = rd_row_reg;
        cols_lim_next  = cols_lim_reg;
        rows_lim_next  = rows_lim_reg;

        if (push) begin
            if (wr_col_reg == '0) begin
                cols_lim_next[wr_bank_reg] = cfg_cols_map;
                rows_lim_next[wr_bank_reg] = cfg_rows_map;
            end
            if (wr_col_reg == col_limit - CW'(1)) begin
                bank_full_next[wr_bank_reg] = 1'b1;
                wr_col_next  = '0;
                wr_bank_next = ~wr_bank_reg;
            end else begin
                wr_col_next = wr_col_reg + CW'(1);
            end
        end

        // Push and pop never address the same bank, so both updates can coexist.
        if (pop) begin
            if (rd_row_reg == rows_lim_reg[rd_bank_reg] - RW'(1)) begin
                bank_full_next[rd_bank_reg] = 1'b0;
                rd_row_next  = '0;
                rd_bank_next = ~rd_bank_reg;
            end else begin
                rd_row_next = rd_row_reg + RW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            bank_full_reg <= '0;
            wr_col_reg    <= '0;
            rd_row_reg    <= '0;
            cols_lim_reg  <= {2{CW'(N)}};
            rows_lim_reg  <= {2{RW'(Width)}};
        end else begin
            wr_bank_reg   <= wr_bank_next;
            rd_bank_reg   <= rd_bank_next;
            bank_full_reg <= bank_full_next;
            wr_col_reg    <= wr_col_next;
            rd_row_reg    <= rd_row_next;
            cols_lim_reg  <= cols_lim_next;
            rows_lim_reg  <= rows_lim_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            redmule_z_store_bank #(
                .DW    (DW),
                .BITW  (BITW),
                .Width (Width)
            ) i_bank (
                .clk_i   (clk_i),
                .wr_en   (push && (wr_bank_reg == 1'(gi))),
                .wr_col  (wr_col_reg[CIW-1:0]),
                .wr_data (in_data_i),
                .rd_row  (rd_row_reg[RIW-1:0]),
                .rd_data (bank_word[gi])
            );
        end

        assign rd_word = bank_word[rd_bank_reg];
        assign cols_rd = cols_lim_reg[rd_bank_reg];

        // Columns beyond the tile's latched width may hold stale data; mask them.
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign out_data_o[gi*BITW +: BITW] =
                (CW'(gi) < cols_rd) ? rd_word[gi*BITW +: BITW] : '0;
            assign out_strb_o[gi*BB +: BB] = {BB{out_valid_o && (CW'(gi) < cols_rd)}};
        end

        if (N * BITW < DW) begin : g_pad
            assign out_data_o[DW-1:N*BITW] = '0;
            assign out_strb_o[DW/8-1:N*BB] = '0;
        end
    endgenerate

    cfg_in_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_valid_i && in_ready_o && wr_col_reg == '0)
        |-> (cfg_cols_i <= CW'(N) && cfg_rows_i <= RW'(Width)));

endmodule

// File: tb/tb_redmule_z_store_buffer.sv
// Directed and random bench for the Z store buffer (W=4, DW=64, FP16 -> N=4),
// checked against a tile-level queue model.
module tb_redmule_z_store_buffer;
    import redmule_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n, clear;
    logic [2:0]           cfg_cols;
    logic [2:0]           cfg_rows;
    logic                 in_valid, in_ready;
    logic [3:0][15:0]     in_data;
    logic                 out_valid, out_ready;
    logic [63:0]          out_data;
    logic [7:0]           out_strb;
    z_store_flgs_t        flags;

    always #5 clk = ~clk;

    redmule_z_store_buffer #(
        .DW       (64),
        .FpFormat (FP16),
        .Width    (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .cfg_cols_i  (cfg_cols),
        .cfg_rows_i  (cfg_rows),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .flags_o     (flags)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
    } word_t;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    logic        last_push;

    // Model: the tile under construction plus queues of completed words/tiles.
    word_t       exp_q[$];
    int          rows_left[$];
    logic [15:0] tile [4][4];
    int          m_col, m_cols, m_rows;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rows_left.delete();
        m_col = 0;
    endtask

    task automatic model_push(input logic [3:0][15:0] d, input int cc, input int cr);
        word_t wd;
        if (m_col == 0) begin
            m_cols = (cc == 0) ? 4 : cc;
            m_rows = (cr == 0) ? 4 : cr;
        end
        for (int w = 0; w < 4; w++) tile[w][m_col] = d[w];
        m_col++;
        if (m_col == m_cols) begin
            for (int r = 0; r < m_rows; r++) begin
                wd.d = '0;
                wd.s = '0;
                for (int c = 0; c < m_cols; c++) begin
                    wd.d[c*16 +: 16] = tile[r][c];
                    wd.s[c*2 +: 2]   = 2'b11;
                end
                exp_q.push_back(wd);
            end
            rows_left.push_back(m_rows);
            m_col = 0;
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model, move past the rising edge.
    task automatic tick();
        logic pop_now, push_now;
        int   pend;
        @(negedge clk);
        pend = rows_left.size();
        pop_now  = out_valid && out_ready;
        push_now = in_valid && in_ready;
        chk("ctl", {in_ready, out_valid, flags.empty, flags.full},
            {pend < 2, pend > 0, pend == 0, pend == 2});
        if (pend > 0 && exp_q.size() > 0) begin
            chk("data", out_data, exp_q[0].d);
            chk("strb", {56'b0, out_strb}, {56'b0, exp_q[0].s});
        end else begin
            chk("strb_idle", {56'b0, out_strb}, 64'h0);
        end
        last_push = push_now;
        if (!rst_n || clear) begin
            model_reset();
        end else begin
            if (pop_now && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pops++;
                rows_left[0] = rows_left[0] - 1;
                if (rows_left[0] == 0) void'(rows_left.pop_front());
            end
            if (push_now) model_push(in_data, int'(cfg_cols), int'(cfg_rows));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_col(input logic [3:0][15:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            tick();
            n++;
        end while (!last_push && n < 40);
        chk("push_timeout", {63'b0, last_push}, 64'h1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'h0);
    endtask

    function automatic logic [3:0][15:0] pat(input int c);
        logic [3:0][15:0] d;
        for (int w = 0; w < 4; w++) d[w] = 16'((w << 12) | (c << 8));
        return d;
    endfunction

    function automatic logic [3:0][15:0] rnd();
        logic [3:0][15:0] d;
        for (int w = 0; w < 4; w++) d[w] = 16'($urandom());
        return d;
    endfunction

    initial begin
        int p0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_cols = 3'd0; cfg_rows = 3'd0; in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_ready", {63'b0, in_ready}, 64'h1);
        chk("rst_empty", {63'b0, flags.empty}, 64'h1);
        chk("rst_full", {63'b0, flags.full}, 64'h0);

        // Full tile with default config
        for (int c = 0; c < 4; c++) push_col(pat(c));
        chk("t1_row0", out_data, 64'h0300_0200_0100_0000);
        chk("t1_strb", {56'b0, out_strb}, 64'hFF);
        p0 = pops;
        drain();
        chk("t1_words", 64'(pops - p0), 64'd4);

        // Leftover tile: 3 columns, 2 rows
        cfg_cols = 3'd3; cfg_rows = 3'd2;
        p0 = pops;
        for (int c = 0; c < 3; c++) push_col(rnd());
        chk("left_strb", {56'b0, out_strb}, 64'h3F);
        chk("left_top", {48'b0, out_data[63:48]}, 64'h0);
        drain();
        chk("left_words", 64'(pops - p0), 64'd2);
        chk("left_empty", {63'b0, flags.empty}, 64'h1);

        // Backpressure: two tiles fill, the third push stalls
        cfg_cols = 3'd0; cfg_rows = 3'd0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) push_col(rnd());
        in_valid = 1'b1;
        in_data  = rnd();
        chk("bp_full", {63'b0, flags.full}, 64'h1);
        chk("bp_ready", {63'b0, in_ready}, 64'h0);
        repeat (3) tick();
        chk("bp_no_push", {63'b0, last_push}, 64'h0);
        in_valid = 1'b0;
        p0 = pops;
        drain();
        chk("bp_words", 64'(pops - p0), 64'd8);

        // Concurrency: drain tile A while filling tile B every cycle
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) push_col(rnd());
        out_ready = 1'b1;
        p0 = pops;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = rnd();
            tick();
            chk("conc_push", {63'b0, last_push}, 64'h1);
        end
        in_valid = 1'b0;
        drain();
        chk("conc_words", 64'(pops - p0), 64'd8);

        // Soft clear after two columns, then a 2-column tile with the new config
        push_col(rnd());
        push_col(rnd());
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_empty", {63'b0, flags.empty}, 64'h1);
        chk("clr_valid", {63'b0, out_valid}, 64'h0);
        cfg_cols = 3'd2; cfg_rows = 3'd3;
        push_col(rnd());
        push_col(rnd());
        chk("clr_newtile", {63'b0, out_valid}, 64'h1);
        drain();

        // Reset for one cycle in the middle of a drain
        cfg_cols = 3'd0; cfg_rows = 3'd0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) push_col(rnd());
        out_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", {63'b0, out_valid}, 64'h0);
        chk("mid_rst_ready", {63'b0, in_ready}, 64'h1);
        chk("mid_rst_empty", {63'b0, flags.empty}, 64'h1);
        for (int c = 0; c < 4; c++) push_col(rnd());
        drain();

        // Random traffic with random in-range config
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rnd();
            cfg_cols  = 3'($urandom_range(0, 4));
            cfg_rows  = 3'($urandom_range(0, 4));
            tick();
        end
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
